// File: rtl/edge_pipeline_sequencer.sv
// Frame sequencer for the edge-detection pipeline: loads a frame, kicks each
// processing stage in turn under a watchdog, then streams result addresses out.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start_processing
// S_LOAD      | accepting N input pixels into the frame buffer
// S_GAUSS     | gaussian blur stage running
// S_SOBEL     | sobel gradient stage running
// S_STRENGTH  | gradient strength stage running
// S_DIRECTION | gradient direction stage running
// S_HYST      | hysteresis stage running
// S_OUTPUT    | presenting N result addresses downstream
// S_DONE      | single-cycle frame completion
module edge_pipeline_sequencer #(
    parameter int  Image_Width   = 512,
    parameter int  Image_Height  = 512,
    parameter int  Stage_Timeout = 1048576,
    localparam int N             = Image_Width * Image_Height,
    localparam int AW            = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          start_processing,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [4:0]    stage_start,
    input  logic [4:0]    stage_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] rd_addr,
    output logic          busy,
    output logic          frame_done,
    output logic          timeout_err
);

    localparam int TW = (Stage_Timeout > 1) ? $clog2(Stage_Timeout) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_GAUSS,
        S_SOBEL,
        S_STRENGTH,
        S_DIRECTION,
        S_HYST,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   pix_q;
    logic [TW-1:0]   wdog_q;
    logic            pix_inc;
    logic            pix_clr;
    logic            err_set;
    logic            err_clr;
    logic [4:0]      cur_stage;
    logic            done_ok;
    logic            wdog_last;
    logic            pix_last;

    function automatic logic [4:0] stage_onehot(input state_t s);
        case (s)
            S_GAUSS:     return 5'b00001;
            S_SOBEL:     return 5'b00010;
            S_STRENGTH:  return 5'b00100;
            S_DIRECTION: return 5'b01000;
            S_HYST:      return 5'b10000;
            default:     return 5'b00000;
        endcase
    endfunction

    assign cur_stage = stage_onehot(state_q);
    // done is only trusted from the second stage cycle, so a level left over
    // from the previous stage cannot skip this one
    assign done_ok   = (|(stage_done & cur_stage)) && (wdog_q != '0);
    assign wdog_last = (wdog_q == TW'(Stage_Timeout - 1));
    assign pix_last  = (pix_q == AW'(N - 1));

    assign in_ready    = (state_q == S_LOAD);
    assign wr_en       = in_valid & in_ready;
    assign wr_addr     = pix_q;
    assign out_valid   = (state_q == S_OUTPUT);
    assign rd_addr     = pix_q;
    assign busy        = (state_q != S_IDLE);
    // an abort landing on the DONE cycle discards the frame, so no pulse
    assign frame_done  = (state_q == S_DONE) & ~abort;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pix_inc = 1'b0;
        pix_clr = 1'b0;
        err_set = 1'b0;
        err_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_processing) begin
                    state_d = S_LOAD;
                    pix_clr = 1'b1;
                    err_clr = 1'b1;
                end
            end
            S_LOAD: begin
                if (wr_en) begin
                    if (pix_last) begin
                        state_d = S_GAUSS;
                        pix_clr = 1'b1;
                    end else begin
                        pix_inc = 1'b1;
                    end
                end
            end
            S_GAUSS:     if (done_ok) state_d = S_SOBEL;
            S_SOBEL:     if (done_ok) state_d = S_STRENGTH;
            S_STRENGTH:  if (done_ok) state_d = S_DIRECTION;
            S_DIRECTION: if (done_ok) state_d = S_HYST;
            S_HYST:      if (done_ok) state_d = S_OUTPUT;
            S_OUTPUT: begin
                if (out_ready) begin
                    if (pix_last) begin
                        state_d = S_DONE;
                        pix_clr = 1'b1;
                    end else begin
                        pix_inc = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((cur_stage != 5'b00000) && !done_ok && wdog_last) begin
            state_d = S_IDLE;
            err_set = 1'b1;
        end

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pix_inc = 1'b0;
            pix_clr = 1'b1;
            err_set = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pix_q       <= '0;
            wdog_q      <= '0;
            stage_start <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pix_clr) begin
                pix_q <= '0;
            end else if (pix_inc) begin
                pix_q <= pix_q + AW'(1);
            end

            // runs only while staying in one stage; any transition restarts it
            if ((state_d == state_q) && (cur_stage != 5'b00000)) begin
                wdog_q <= wdog_q + TW'(1);
            end else begin
                wdog_q <= '0;
            end

            stage_start <= (state_d != state_q) ? stage_onehot(state_d) : 5'b00000;

            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/edge_pipeline_sequencer.md
EDGE_PIPELINE_SEQUENCER -- requirements
Module: edge_pipeline_sequencer

Interface
REQ-001 SHALL provide parameter Image_Width, default 512, pixels per row.
REQ-002 SHALL provide parameter Image_Height, default 512, rows per frame.
REQ-003 SHALL provide parameter Stage_Timeout, default 1048576, the per-stage watchdog limit in cycles.
REQ-004 SHALL derive N = Image_Width*Image_Height and AW = clog2(N) (minimum 1); neither is overridable.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rstN  in  1  asynchronous active-low reset.
REQ-008 start_processing  in  1  frame start request.
REQ-009 abort  in  1  synchronous abort of the current frame.
REQ-010 in_valid  in  1  input pixel present.
REQ-011 in_ready  out  1  sequencer accepts input pixels.
REQ-012 wr_en  out  1  frame-buffer write strobe (BeginWrite).
REQ-013 wr_addr  out  AW  frame-buffer write address.
REQ-014 stage_start  out  5  one-hot start pulses: bit0 gauss, bit1 sobel, bit2 strength, bit3 direction, bit4 hysteresis.
REQ-015 stage_done  in  5  per-stage completion, same bit order.
REQ-016 out_valid  out  1  output pixel address valid.
REQ-017 out_ready  in  1  downstream accepts the output pixel.
REQ-018 rd_addr  out  AW  result-buffer read address.
REQ-019 busy  out  1  sequencer not idle.
REQ-020 frame_done  out  1  single-cycle frame completion pulse.
REQ-021 timeout_err  out  1  sticky watchdog error flag.

Function
REQ-022 SHALL implement the states IDLE, LOAD, GAUSS, SOBEL, STRENGTH, DIRECTION, HYST, OUTPUT and DONE.
REQ-023 SHALL move from IDLE to LOAD on start_processing, clearing the pixel counter and timeout_err; start_processing SHALL be ignored in every other state.
REQ-024 SHALL hold in_ready=1 only in LOAD, with wr_en = in_valid & in_ready combinationally and wr_addr = the pixel counter.
REQ-025 SHALL increment the pixel counter on each accepted input pixel; after the N-th acceptance (counter N-1), the next state SHALL be GAUSS and the counter SHALL reset to 0.
REQ-026 SHALL step through the stage states in the order GAUSS, SOBEL, STRENGTH, DIRECTION, HYST.
REQ-027 SHALL assert the matching stage_start bit, registered, for exactly the first cycle of each stage state; all other bits are 0.
REQ-028 SHALL sample stage_done[i] only from the second cycle of stage i; done seen on the start cycle is ignored and other stage_done bits are ignored; on a valid done the FSM SHALL advance on the next edge.
REQ-029 SHALL clear the watchdog counter on entry to each stage state and increment it each cycle in the stage; at Stage_Timeout-1 without done, it SHALL set timeout_err and return to IDLE.
REQ-030 SHALL in OUTPUT hold out_valid=1 with rd_addr = the pixel counter, advancing on out_valid & out_ready; after the N-th handshake the next state SHALL be DONE.
REQ-031 SHALL in DONE assert frame_done for one cycle, then return to IDLE.
REQ-032 SHALL, on abort in any non-IDLE state, enter IDLE on the next edge with counters cleared, no frame_done, and timeout_err unchanged.
REQ-033 SHALL let abort win over any simultaneous done, handshake or timeout in the same cycle.
REQ-034 SHALL drive busy=1 in every state except IDLE.
REQ-035 SHALL process exactly one frame per start; a new frame needs a new start_processing in IDLE.

Reset
REQ-036 SHALL on rstN low asynchronously force the state to IDLE and all counters to 0.
REQ-037 SHALL hold every output at 0 during reset, including timeout_err.
REQ-038 SHALL, if reset occurs mid-frame, discard the frame with no frame_done pulse.

Verification (Image_Width=4, Image_Height=2, Stage_Timeout=16)
REQ-039 Full frame: start, 8 valid pixels, each stage_done 3 cycles after its start, out_ready=1 -> wr_addr 0..7, five single-cycle start pulses in order, rd_addr 0..7, frame_done once, busy low after.
REQ-040 Backpressure: in_valid toggling and out_ready low every other cycle -> exactly 8 writes and 8 reads, with no address skipped or repeated.
REQ-041 Timeout: stage_done[1] never asserted -> timeout_err=1 sixteen cycles after the sobel start, state IDLE, no frame_done; a new start clears timeout_err.
REQ-042 Abort: abort during STRENGTH together with stage_done[2] -> IDLE next cycle, no stage_start[3], busy=0.
REQ-043 Stray inputs: start_processing during LOAD and stage_done[4] during GAUSS -> both ignored, pixel counter and sequence unchanged.
REQ-044 Reset: rstN low mid-OUTPUT -> all outputs 0 immediately (asynchronously), no frame_done.
